// File: rtl/updown_chk_pkg.sv
// Shared definitions for the up/down counter step checker.
package updown_chk_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACQ   = 2'd1;
    localparam logic [1:0] S_TRACK = 2'd2;

    localparam int COUNT_W = 4;

    typedef enum logic [1:0] {
        STEP_GOOD = 2'd0,
        STEP_HOLD = 2'd1,
        STEP_BAD  = 2'd2
    } step_t;

    // Classify one observed step; an unchanged count is only a legal hold when allowed.
    function automatic step_t classify_step(input logic [COUNT_W-1:0] prev,
                                            input logic [COUNT_W-1:0] cnt,
                                            input logic               dir,
                                            input logic               allow_hold);
        logic [COUNT_W-1:0] one;
        logic [COUNT_W-1:0] exp_nxt;
        one     = {{(COUNT_W-1){1'b0}}, 1'b1};
        exp_nxt = dir ? (prev + one) : (prev - one);
        if (cnt == exp_nxt)
            return STEP_GOOD;
        else if (cnt == prev)
            return allow_hold ? STEP_HOLD : STEP_BAD;
        else
            return STEP_BAD;
    endfunction

endpackage

// File: rtl/updown_step_checker_sat_counter.sv
// Saturating event counter; clear wins over a coincident increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count up on inc, stick at all-ones, zero on rst or clr.
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != {W{1'b1}}))
            q <= q + W'(1);
    end

endmodule

// File: rtl/updown_step_checker.sv
// Monitors a 4-bit up/down counter: step legality, wrap events and lock state.
module updown_step_checker
    import updown_chk_pkg::*;
#(
    parameter int LOCK_N     = 2,
    parameter int ALLOW_HOLD = 0,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up_down,
    input  logic [COUNT_W-1:0] count,
    input  logic               clr,
    output logic               locked,
    output logic               err_pulse,
    output logic               wrap_up,
    output logic               wrap_dn,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   wrap_cnt
);

    localparam logic [3:0] LOCK_V = 4'(LOCK_N);

    logic [1:0]         state, state_d;
    logic [3:0]         good_cnt, good_d;
    logic [COUNT_W-1:0] prev;
    logic               dir_q;
    step_t              step;
    logic               ok;
    logic               eval;
    logic               err_d, wu_d, wd_d;

    assign step = classify_step(prev, count, dir_q, ALLOW_HOLD != 0);
    assign ok   = (step != STEP_BAD);
    assign eval = (state == S_ACQ) || (state == S_TRACK);

    // State, acquisition progress and the previous sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            good_cnt <= 4'd0;
            prev     <= '0;
            dir_q    <= 1'b0;
        end else begin
            state    <= state_d;
            good_cnt <= good_d;
            prev     <= count;
            dir_q    <= up_down;
        end
    end

    // Lock acquisition: LOCK_N consecutive good steps enter TRACK, any bad step restarts.
    always_comb begin
        state_d = state;
        good_d  = good_cnt;
        case (state)
            S_IDLE: begin
                state_d = S_ACQ;
                good_d  = 4'd0;
            end
            S_ACQ: begin
                if (ok) begin
                    good_d = good_cnt + 4'd1;
                    if ((good_cnt + 4'd1) >= LOCK_V)
                        state_d = S_TRACK;
                end else begin
                    good_d = 4'd0;
                end
            end
            S_TRACK: begin
                if (!ok) begin
                    state_d = S_ACQ;
                    good_d  = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                good_d  = 4'd0;
            end
        endcase
    end

    // Event decode; errors only count once locked, wraps need a real (non-hold) step.
    always_comb begin
        err_d = (state == S_TRACK) && !ok;
        wu_d  = eval && (step == STEP_GOOD) && dir_q
                && (prev == 4'hF) && (count == 4'h0);
        wd_d  = eval && (step == STEP_GOOD) && !dir_q
                && (prev == 4'h0) && (count == 4'hF);
    end

    // Registered status outputs, high the cycle after the evaluating edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            wrap_up   <= 1'b0;
            wrap_dn   <= 1'b0;
        end else begin
            locked    <= (state_d == S_TRACK);
            err_pulse <= err_d;
            wrap_up   <= wu_d;
            wrap_dn   <= wd_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (err_d),
        .q   (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wrap_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (wu_d | wd_d),
        .q   (wrap_cnt)
    );

endmodule

// File: doc/updown_step_checker.md
Name: updown_step_checker

Overview:
- Downstream monitor that consumes the 4-bit output and direction control of the 4-bit up/down counter.
- Checks on every clock that each new count is exactly one step from the previous count, in the commanded direction, modulo 16.
- Reports step errors, up/down wrap events and lock status to the surrounding test or debug logic.
- Sits on the same clock as the counter and shares its reset.

Parameters:
- LOCK_N, 2: consecutive good steps required before the checker declares lock (1..15).
- ALLOW_HOLD, 0: 1 = an unchanged count is a legal step; 0 = an unchanged count is an error.
- CNT_W, 8: width of the saturating error and wrap event counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- up_down  in  1  direction driven to the counter (1 = up, 0 = down).
- count  in  4  counter output.
- clr  in  1  synchronous clear of err_cnt and wrap_cnt only.
- locked  out  1  high while in TRACK.
- err_pulse  out  1  one-cycle pulse on an illegal step while locked.
- wrap_up  out  1  one-cycle pulse on a good 15->0 step.
- wrap_dn  out  1  one-cycle pulse on a good 0->15 step.
- err_cnt  out  CNT_W  saturating count of err_pulse events.
- wrap_cnt  out  CNT_W  saturating count of wrap_up plus wrap_dn events.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; locked, err_pulse, wrap_up and wrap_dn = 0.
  - err_cnt, wrap_cnt, good_cnt, prev and dir_q = 0.
  - rst overrides every other input, including mid-operation; the checker restarts from IDLE.
- Sampling: every non-reset edge loads prev<=count and dir_q<=up_down. At edge k, count reflects the counter update made with up_down from edge k-1.
- Step evaluation at each edge, comparing count against prev using dir_q:
  - Good up: dir_q=1 and count == prev+1 mod 16.
  - Good down: dir_q=0 and count == prev-1 mod 16.
  - Hold: count == prev; good only if ALLOW_HOLD=1.
  - Anything else is bad.
- FSM:
  - IDLE: no valid prev. Next edge captures a sample and goes to ACQ with good_cnt=0; no evaluation is made on this edge.
  - ACQ: a good step increments good_cnt. When good_cnt reaches LOCK_N, go to TRACK. A bad step sets good_cnt=0, stays in ACQ and does not assert err_pulse.
  - TRACK: a good step stays in TRACK. A bad step asserts err_pulse, increments err_cnt, goes to ACQ and sets good_cnt=0.
- Wrap detection, on good steps in ACQ or TRACK:
  - prev=15, count=0, dir_q=1 -> wrap_up.
  - prev=0, count=15, dir_q=0 -> wrap_dn.
  - Either pulse increments wrap_cnt.
- Latency: all outputs are registered. Pulses are high for exactly the one cycle after the evaluating edge.
- Saturation: err_cnt and wrap_cnt stop at 2^CNT_W-1 and never roll over.
- Simultaneous events: clr and an increment in the same edge leave the counter at 0, but the pulse output is still asserted.
- Direction change: a change of up_down takes effect for the step evaluated one edge later (via dir_q). A reversal is never itself an error.

Decomposition:
- Shared package updown_chk_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_ACQ=2'd1, S_TRACK=2'd2;
  - COUNT_W=4;
  - the step-classification function (prev, count, dir, allow_hold -> good/hold/bad).
- One sub-module, sat_counter (parameter W; inputs clk, rst, clr, inc; output q), instantiated twice, for err_cnt and wrap_cnt.

Test Plan:
- Lock and up wrap: hold rst=1 for 2 cycles, release it with up_down=1, and drive a reference up-counter 0..15,0,1. Required: locked=1 after the 3rd post-reset edge (LOCK_N=2). Exactly one wrap_up pulse, on the 15->0 step, with wrap_cnt=1. err_cnt=0 throughout.
- Injected glitch while locked: drive count 4,5,7. Required: err_pulse for exactly 1 cycle, err_cnt=1 and locked=0. Continuing with 8,9 gives locked=1 again after 2 good steps.
- Direction reversal with down wrap: drive up to 2, set up_down=0, then drive 1,0,15,14. Required: no err_pulse, one wrap_dn pulse on 0->15, wrap_cnt increments by 1.
- Hold handling: repeat count 6 for two cycles while locked. With ALLOW_HOLD=0, err_pulse=1 and err_cnt=1. With ALLOW_HOLD=1, no error and locked stays 1.
- Saturation and clear: with CNT_W=2, inject 5 errors, relocking between each. Required: err_cnt=3, not 1. Then assert clr on the same edge as a 6th error: err_pulse=1 and err_cnt=0.
- Reset mid-TRACK: assert rst for 1 cycle while locked with err_cnt=2. Required: every output is 0 on the next cycle; relock takes 1 capture edge plus LOCK_N good steps.
